// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: decode-side operands/control, EX/MEM and MEM/WB forwarding
// sources, and the ALU-facing outputs of the stage.
interface id_ex_stage_if #(
  parameter int SIZE = 32,
  parameter int REGW = 5
);
  logic            stall;
  logic            flush;
  logic            id_valid;
  logic [SIZE-1:0] id_rs_data;
  logic [SIZE-1:0] id_rt_data;
  logic [SIZE-1:0] id_imm;
  logic [REGW-1:0] id_rs;
  logic [REGW-1:0] id_rt;
  logic [REGW-1:0] id_rd;
  logic [3:0]      id_alu_cnt;
  logic [4:0]      id_shamt;
  logic            id_alu_src;
  logic            id_reg_write;
  logic            exm_reg_write;
  logic [REGW-1:0] exm_rd;
  logic [SIZE-1:0] exm_result;
  logic            wb_reg_write;
  logic [REGW-1:0] wb_rd;
  logic [SIZE-1:0] wb_result;
  logic [SIZE-1:0] input1;
  logic [SIZE-1:0] input2;
  logic [3:0]      ALUCnt;
  logic [4:0]      shamt;
  logic [SIZE-1:0] store_data;
  logic [REGW-1:0] ex_rd;
  logic            ex_reg_write;
  logic            ex_valid;
  logic [1:0]      fwd_a;
  logic [1:0]      fwd_b;

  modport master (
    output stall, flush, id_valid, id_rs_data, id_rt_data, id_imm, id_rs, id_rt,
           id_rd, id_alu_cnt, id_shamt, id_alu_src, id_reg_write,
           exm_reg_write, exm_rd, exm_result, wb_reg_write, wb_rd, wb_result,
    input  input1, input2, ALUCnt, shamt, store_data, ex_rd, ex_reg_write,
           ex_valid, fwd_a, fwd_b
  );

  modport slave (
    input  stall, flush, id_valid, id_rs_data, id_rt_data, id_imm, id_rs, id_rt,
           id_rd, id_alu_cnt, id_shamt, id_alu_src, id_reg_write,
           exm_reg_write, exm_rd, exm_result, wb_reg_write, wb_rd, wb_result,
    output input1, input2, ALUCnt, shamt, store_data, ex_rd, ex_reg_write,
           ex_valid, fwd_a, fwd_b
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding feeding the ALU.
// Priority per edge: reset > flush > stall > load.
module id_ex_stage #(
  parameter int SIZE = 32,
  parameter int REGW = 5
) (
  input logic         clk,
  input logic         rst_n,
  id_ex_stage_if.slave bus
);

  typedef struct packed {
    logic            valid;
    logic [SIZE-1:0] rs_data;
    logic [SIZE-1:0] rt_data;
    logic [SIZE-1:0] imm;
    logic [REGW-1:0] rs;
    logic [REGW-1:0] rt;
    logic [REGW-1:0] rd;
    logic [3:0]      alu_cnt;
    logic [4:0]      shamt;
    logic            alu_src;
    logic            reg_write;
  } stage_t;

  stage_t          r_stage;
  logic [1:0]      w_fwd_a;
  logic [1:0]      w_fwd_b;
  logic [SIZE-1:0] w_op_a;
  logic [SIZE-1:0] w_op_b;

  always_ff @(posedge clk) begin
    if (!rst_n || bus.flush) begin
      r_stage <= '0;
    end else if (!bus.stall) begin
      r_stage.valid     <= bus.id_valid;
      r_stage.rs_data   <= bus.id_rs_data;
      r_stage.rt_data   <= bus.id_rt_data;
      r_stage.imm       <= bus.id_imm;
      r_stage.rs        <= bus.id_rs;
      r_stage.rt        <= bus.id_rt;
      r_stage.rd        <= bus.id_rd;
      r_stage.alu_cnt   <= bus.id_alu_cnt;
      r_stage.shamt     <= bus.id_shamt;
      r_stage.alu_src   <= bus.id_alu_src;
      r_stage.reg_write <= bus.id_reg_write & bus.id_valid;
    end
  end

  // Forwarding uses live producer buses so results retiring during a stall are seen.
  always_comb begin
    w_fwd_a = 2'b00;
    w_fwd_b = 2'b00;
    if (bus.exm_reg_write && bus.exm_rd != '0 && bus.exm_rd == r_stage.rs)
      w_fwd_a = 2'b10;
    else if (bus.wb_reg_write && bus.wb_rd != '0 && bus.wb_rd == r_stage.rs)
      w_fwd_a = 2'b01;
    if (bus.exm_reg_write && bus.exm_rd != '0 && bus.exm_rd == r_stage.rt)
      w_fwd_b = 2'b10;
    else if (bus.wb_reg_write && bus.wb_rd != '0 && bus.wb_rd == r_stage.rt)
      w_fwd_b = 2'b01;

    case (w_fwd_a)
      2'b10:   w_op_a = bus.exm_result;
      2'b01:   w_op_a = bus.wb_result;
      default: w_op_a = r_stage.rs_data;
    endcase
    case (w_fwd_b)
      2'b10:   w_op_b = bus.exm_result;
      2'b01:   w_op_b = bus.wb_result;
      default: w_op_b = r_stage.rt_data;
    endcase
  end

  assign bus.input1       = w_op_a;
  assign bus.store_data   = w_op_b;
  assign bus.input2       = r_stage.alu_src ? r_stage.imm : w_op_b;
  assign bus.ALUCnt       = r_stage.alu_cnt;
  assign bus.shamt        = r_stage.shamt;
  assign bus.ex_rd        = r_stage.rd;
  assign bus.ex_reg_write = r_stage.reg_write & r_stage.valid;
  assign bus.ex_valid     = r_stage.valid;
  assign bus.fwd_a        = w_fwd_a;
  assign bus.fwd_b        = w_fwd_b;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: an instruction-level model of what sits in EX,
// checked every cycle, plus literal expectations from hand-worked vectors.
module tb_id_ex_stage;
  localparam int SIZE = 32;
  localparam int REGW = 5;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;
  bit   chk_en;

  id_ex_stage_if #(.SIZE(SIZE), .REGW(REGW)) bus();

  id_ex_stage #(.SIZE(SIZE), .REGW(REGW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction currently resident in EX, as decode handed it over.
  typedef struct {
    bit              valid;
    logic [SIZE-1:0] a, b, imm;
    logic [REGW-1:0] rs, rt, rd;
    logic [3:0]      op;
    logic [4:0]      sh;
    bit              use_imm, writes;
  } instr_t;

  instr_t ex;
  instr_t bubble;

  initial begin
    bubble = '{valid: 0, a: 0, b: 0, imm: 0, rs: 0, rt: 0, rd: 0, op: 0, sh: 0,
               use_imm: 0, writes: 0};
    ex = bubble;
  end

  always @(posedge clk) begin
    if (!rst_n || bus.flush) ex <= bubble;
    else if (!bus.stall)
      ex <= '{valid: bus.id_valid, a: bus.id_rs_data, b: bus.id_rt_data,
              imm: bus.id_imm, rs: bus.id_rs, rt: bus.id_rt, rd: bus.id_rd,
              op: bus.id_alu_cnt, sh: bus.id_shamt, use_imm: bus.id_alu_src,
              writes: bus.id_reg_write && bus.id_valid};
  end

  // Value of architectural register r as EX should see it: the youngest in-flight
  // writer wins; r0 is hardwired and always reads from the register file.
  function automatic logic [SIZE-1:0] see_reg(input logic [REGW-1:0] r,
                                             input logic [SIZE-1:0] rf_val,
                                             output logic [1:0] src);
    src = 2'b00;
    if (r == 0) return rf_val;
    if (bus.exm_reg_write && bus.exm_rd == r) begin src = 2'b10; return bus.exm_result; end
    if (bus.wb_reg_write && bus.wb_rd == r) begin src = 2'b01; return bus.wb_result; end
    return rf_val;
  endfunction

  task automatic cmp(input string name, input logic [SIZE-1:0] act, input logic [SIZE-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      logic [SIZE-1:0] ea, eb;
      logic [1:0] sa, sb;
      ea = see_reg(ex.rs, ex.a, sa);
      eb = see_reg(ex.rt, ex.b, sb);
      cmp("model.input1",       bus.input1, ea);
      cmp("model.store_data",   bus.store_data, eb);
      cmp("model.input2",       bus.input2, ex.use_imm ? ex.imm : eb);
      cmp("model.ALUCnt",       SIZE'(bus.ALUCnt), SIZE'(ex.op));
      cmp("model.shamt",        SIZE'(bus.shamt), SIZE'(ex.sh));
      cmp("model.ex_rd",        SIZE'(bus.ex_rd), SIZE'(ex.rd));
      cmp("model.ex_reg_write", SIZE'(bus.ex_reg_write), SIZE'(ex.writes));
      cmp("model.ex_valid",     SIZE'(bus.ex_valid), SIZE'(ex.valid));
      cmp("model.fwd_a",        SIZE'(bus.fwd_a), SIZE'(sa));
      cmp("model.fwd_b",        SIZE'(bus.fwd_b), SIZE'(sb));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Literal checks run just after the model compare on the same falling edge.
  task automatic at_check();
    @(negedge clk);
    #2;
  endtask

  task automatic load(input bit v, input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                      input logic [SIZE-1:0] imm, input logic [REGW-1:0] rs,
                      input logic [REGW-1:0] rt, input logic [REGW-1:0] rd,
                      input logic [3:0] op, input logic [4:0] sh, input bit src, input bit rw);
    bus.id_valid = v;     bus.id_rs_data = a;  bus.id_rt_data = b; bus.id_imm = imm;
    bus.id_rs = rs;       bus.id_rt = rt;      bus.id_rd = rd;
    bus.id_alu_cnt = op;  bus.id_shamt = sh;   bus.id_alu_src = src;
    bus.id_reg_write = rw;
  endtask

  task automatic producers(input bit ew, input logic [REGW-1:0] erd, input logic [SIZE-1:0] er,
                           input bit ww, input logic [REGW-1:0] wrd, input logic [SIZE-1:0] wr);
    bus.exm_reg_write = ew; bus.exm_rd = erd; bus.exm_result = er;
    bus.wb_reg_write  = ww; bus.wb_rd  = wrd; bus.wb_result  = wr;
  endtask

  task automatic rand_id();
    load(1'($urandom), $urandom, $urandom, $urandom, 5'($urandom), 5'($urandom),
         5'($urandom), 4'($urandom_range(0, 7)), 5'($urandom), 1'($urandom), 1'($urandom));
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; chk_en = 0;
    rst_n = 0; bus.stall = 0; bus.flush = 0;
    producers(0, 0, 0, 0, 0, 0);
    rand_id();
    step();
    chk_en = 1;
    rand_id();
    step();
    at_check();
    cmp("reset.input1", bus.input1, 0);
    cmp("reset.input2", bus.input2, 0);
    cmp("reset.ex_valid", SIZE'(bus.ex_valid), 0);

    // first load after reset: sub 5,3
    rst_n = 1;
    load(1, 32'd5, 32'd3, 0, 5'd1, 5'd2, 5'd3, 4'd1, 0, 0, 1);
    step(); at_check();
    cmp("load.input1", bus.input1, 32'd5);
    cmp("load.input2", bus.input2, 32'd3);
    cmp("load.ALUCnt", SIZE'(bus.ALUCnt), 1);
    cmp("load.ex_valid", SIZE'(bus.ex_valid), 1);

    // EX/MEM beats MEM/WB on rs=8
    load(1, 32'h11, 32'h22, 0, 5'd8, 5'd9, 5'd4, 4'd0, 0, 0, 1);
    producers(1, 5'd8, 32'hAA, 1, 5'd8, 32'hBB);
    step(); at_check();
    cmp("prio.input1", bus.input1, 32'hAA);
    cmp("prio.fwd_a", SIZE'(bus.fwd_a), 2);
    // drop EX/MEM while the stage is held: WB result must still be picked up
    bus.stall = 1;
    producers(0, 5'd8, 32'hAA, 1, 5'd8, 32'hBB);
    step(); at_check();
    cmp("prio.wb.input1", bus.input1, 32'hBB);
    cmp("prio.wb.fwd_a", SIZE'(bus.fwd_a), 1);
    bus.stall = 0;

    // r0 never forwarded
    load(1, 0, 0, 0, 0, 0, 5'd5, 4'd6, 0, 0, 1);
    producers(1, 0, 32'hFFFF, 0, 0, 0);
    step(); at_check();
    cmp("r0.input1", bus.input1, 0);
    cmp("r0.input2", bus.input2, 0);
    cmp("r0.fwd_a", SIZE'(bus.fwd_a), 0);
    cmp("r0.fwd_b", SIZE'(bus.fwd_b), 0);

    // immediate select vs. forwarded store data
    load(1, 32'h1, 32'h99, 32'h10, 5'd3, 5'd4, 5'd6, 4'd0, 0, 1, 1);
    producers(1, 5'd4, 32'h77, 0, 0, 0);
    step(); at_check();
    cmp("imm.input2", bus.input2, 32'h10);
    cmp("imm.store_data", bus.store_data, 32'h77);

    // stall holds instruction A for 3 cycles while decode changes
    producers(0, 0, 0, 0, 0, 0);
    load(1, 32'h1234, 32'h5678, 0, 5'd10, 5'd11, 5'd9, 4'd5, 5'd7, 0, 1);
    step();
    bus.stall = 1;
    for (int i = 0; i < 3; i++) begin
      rand_id();
      step(); at_check();
      cmp("stall.input1", bus.input1, 32'h1234);
      cmp("stall.ALUCnt", SIZE'(bus.ALUCnt), 5);
      cmp("stall.ex_rd", SIZE'(bus.ex_rd), 9);
    end
    // flush wins over stall
    bus.flush = 1;
    step(); at_check();
    cmp("flush.ex_valid", SIZE'(bus.ex_valid), 0);
    cmp("flush.ex_reg_write", SIZE'(bus.ex_reg_write), 0);
    cmp("flush.ALUCnt", SIZE'(bus.ALUCnt), 0);
    bus.stall = 0; bus.flush = 0;

    // invalid load still captures data
    load(0, 32'h42, 32'h43, 0, 5'd12, 5'd13, 5'd14, 4'd6, 0, 0, 1);
    step(); at_check();
    cmp("inv.ex_reg_write", SIZE'(bus.ex_reg_write), 0);
    cmp("inv.ex_valid", SIZE'(bus.ex_valid), 0);
    cmp("inv.input1", bus.input1, 32'h42);

    // mid-stream reset
    load(1, 32'h7, 32'h8, 0, 5'd1, 5'd2, 5'd3, 4'd7, 5'd2, 0, 1);
    step();
    rst_n = 0;
    step(); at_check();
    cmp("rst.input1", bus.input1, 0);
    cmp("rst.ex_valid", SIZE'(bus.ex_valid), 0);
    rst_n = 1;

    // mixed traffic with small register numbers so forwarding collides often
    for (int i = 0; i < 40; i++) begin
      rand_id();
      bus.id_rs = 5'($urandom_range(0, 3));
      bus.id_rt = 5'($urandom_range(0, 3));
      producers(1'($urandom), 5'($urandom_range(0, 3)), $urandom,
                1'($urandom), 5'($urandom_range(0, 3)), $urandom);
      bus.stall = ($urandom_range(0, 3) == 0);
      bus.flush = ($urandom_range(0, 7) == 0);
      step();
    end
    @(negedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
